// File: rtl/alut_lookup_engine16.sv
// Hashed, direct-mapped MAC address lookup engine with source learning,
// timestamp ageing, sticky overwrite detection and deferred table flush.
module alut_lookup_engine16 #(
  parameter  int unsigned NPORTS = 4,
  parameter  int unsigned AW     = 48,
  parameter  int unsigned IDXW   = 8,
  parameter  int unsigned TW     = 32,
  localparam int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int unsigned DEPTH  = 2 ** IDXW
) (
  input  logic            pclk16,
  input  logic            p_reset16,
  input  logic            req_valid16,
  output logic            req_ready16,
  input  logic [AW-1:0]   req_saddr16,
  input  logic [AW-1:0]   req_daddr16,
  input  logic [PW-1:0]   req_sport16,
  output logic            rsp_valid16,
  input  logic            rsp_ready16,
  output logic [NPORTS:0] rsp_dport16,
  output logic            rsp_hit16,
  input  logic [AW-1:0]   mac_addr16,
  input  logic [TW-1:0]   age_limit16,
  input  logic [7:0]      div_clk16,
  input  logic            flush16,
  input  logic            clear_reused16,
  output logic [TW-1:0]   curr_time16,
  output logic            reused16,
  output logic            busy16
);

  typedef enum logic [2:0] {S_IDLE, S_RDD, S_CHKD, S_CHKS, S_RSP, S_FLUSH} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] port;
    logic [TW-1:0] ts;
  } entry_t;

  function automatic logic [IDXW-1:0] hash(input logic [2*IDXW-1:0] a);
    return a[IDXW-1:0] ^ a[2*IDXW-1:IDXW];
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     req_saddr_q, req_saddr_d;
  logic [AW-1:0]     req_daddr_q, req_daddr_d;
  logic [PW-1:0]     req_sport_q, req_sport_d;
  logic [NPORTS:0]   dport_q, dport_d;
  logic              hit_q, hit_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NPORTS:0]   rsp_dport_q, rsp_dport_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              reused_q, reused_d;
  logic              flush_pend_q, flush_pend_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [7:0]        presc_q, presc_d;
  logic [TW-1:0]     curr_time_q, curr_time_d;

  entry_t            mem [DEPTH];
  entry_t            rd_q;
  logic              ram_we;
  logic [IDXW-1:0]   ram_ridx;
  entry_t            ram_wdata;

  logic [IDXW-1:0]   dst_idx, src_idx;
  logic [TW-1:0]     rd_age;
  logic              rd_stale, learn_ok;
  logic [NPORTS:0]   flood, learned;

  always_comb begin
    state_d      = state_q;
    req_saddr_d  = req_saddr_q;
    req_daddr_d  = req_daddr_q;
    req_sport_d  = req_sport_q;
    dport_d      = dport_q;
    hit_d        = hit_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dport_d  = rsp_dport_q;
    rsp_hit_d    = rsp_hit_q;
    reused_d     = reused_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    presc_d      = presc_q + 8'd1;
    curr_time_d  = curr_time_q;

    dst_idx   = hash(req_daddr_q[2*IDXW-1:0]);
    src_idx   = hash(req_saddr_q[2*IDXW-1:0]);
    ram_we    = 1'b0;
    ram_ridx  = dst_idx;
    ram_wdata = '{addr: req_saddr_q, port: req_sport_q, ts: curr_time_q};

    // rd_q holds the daddr entry during CHKD and the saddr entry during CHKS
    rd_age   = curr_time_q - rd_q.ts;
    rd_stale = rd_age > age_limit16;
    learn_ok = (req_saddr_q != mac_addr16) && (req_saddr_q != '1);

    flood   = '0;
    learned = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      flood[p]   = (PW'(p) != req_sport_q);
      learned[p] = (PW'(p) == rd_q.port) && (rd_q.port != req_sport_q);
    end

    if (presc_q >= div_clk16) begin
      presc_d     = '0;
      curr_time_d = curr_time_q + TW'(1);
    end

    if (clear_reused16) reused_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid16 && req_ready_q) begin
          req_saddr_d  = req_saddr16;
          req_daddr_d  = req_daddr16;
          req_sport_d  = req_sport16;
          flush_pend_d = flush16;
          state_d      = S_RDD;
        end else if (flush16 || flush_pend_q) begin
          flush_pend_d = 1'b0;
          state_d      = S_FLUSH;
        end
      end
      S_RDD: state_d = S_CHKD;
      S_CHKD: begin
        ram_ridx = src_idx;
        hit_d    = 1'b0;
        if (req_daddr_q == mac_addr16) begin
          dport_d         = '0;
          dport_d[NPORTS] = 1'b1;
        end else if (req_daddr_q == '1) begin
          dport_d = flood;
        end else if (valid_q[dst_idx] && (rd_q.addr == req_daddr_q) && !rd_stale) begin
          dport_d = learned;
          hit_d   = 1'b1;
        end else begin
          dport_d = flood;
        end
        state_d = S_CHKS;
      end
      S_CHKS: begin
        if (learn_ok) begin
          ram_we           = 1'b1;
          valid_d[src_idx] = 1'b1;
          if (valid_q[src_idx] && !rd_stale && (rd_q.addr != req_saddr_q))
            reused_d = 1'b1;
        end
        state_d = S_RSP;
      end
      S_RSP: begin
        // result is presented one cycle after entering RSP, then held
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_dport_d = dport_q;
          rsp_hit_d   = hit_q;
        end else if (rsp_ready16) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_FLUSH: begin
        valid_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush16 && (state_q != S_IDLE)) flush_pend_d = 1'b1;

    req_ready_d = (state_d == S_IDLE) && !flush_pend_d;
    busy_d      = (state_d != S_IDLE) || flush_pend_d;
  end

  always_ff @(posedge pclk16) begin
    if (p_reset16) begin
      state_q      <= S_IDLE;
      req_saddr_q  <= '0;
      req_daddr_q  <= '0;
      req_sport_q  <= '0;
      dport_q      <= '0;
      hit_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dport_q  <= '0;
      rsp_hit_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      reused_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      presc_q      <= '0;
      curr_time_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_saddr_q  <= req_saddr_d;
      req_daddr_q  <= req_daddr_d;
      req_sport_q  <= req_sport_d;
      dport_q      <= dport_d;
      hit_q        <= hit_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dport_q  <= rsp_dport_d;
      rsp_hit_q    <= rsp_hit_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      reused_q     <= reused_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      presc_q      <= presc_d;
      curr_time_q  <= curr_time_d;
    end
  end

  always_ff @(posedge pclk16) begin
    if (ram_we && !p_reset16) mem[src_idx] <= ram_wdata;
    rd_q <= mem[ram_ridx];
  end

  assign req_ready16 = req_ready_q;
  assign rsp_valid16 = rsp_valid_q;
  assign rsp_dport16 = rsp_dport_q;
  assign rsp_hit16   = rsp_hit_q;
  assign curr_time16 = curr_time_q;
  assign reused16    = reused_q;
  assign busy16      = busy_q;

endmodule

// File: tb/tb_alut_lookup_engine16.sv
// Self-checking bench for alut_lookup_engine16 (TW=4 so time wrap is reachable).
module tb_alut_lookup_engine16;
  localparam logic [47:0] MAC  = 48'h0000_00AB_CDEF;
  localparam logic [47:0] ONES = {48{1'b1}};

  logic        pclk16 = 1'b0;
  logic        p_reset16, req_valid16, req_ready16, rsp_valid16, rsp_ready16;
  logic [47:0] req_saddr16, req_daddr16, mac_addr16;
  logic [1:0]  req_sport16;
  logic [4:0]  rsp_dport16;
  logic        rsp_hit16, flush16, clear_reused16, reused16, busy16;
  logic [3:0]  age_limit16, curr_time16;
  logic [7:0]  div_clk16;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  // reference table, indexed by hash
  logic        m_valid [256];
  logic [47:0] m_addr  [256];
  logic [1:0]  m_port  [256];
  logic [3:0]  m_ts    [256];
  logic        m_reused;

  alut_lookup_engine16 #(.NPORTS(4), .AW(48), .IDXW(8), .TW(4)) dut (
    .pclk16(pclk16), .p_reset16(p_reset16),
    .req_valid16(req_valid16), .req_ready16(req_ready16),
    .req_saddr16(req_saddr16), .req_daddr16(req_daddr16), .req_sport16(req_sport16),
    .rsp_valid16(rsp_valid16), .rsp_ready16(rsp_ready16),
    .rsp_dport16(rsp_dport16), .rsp_hit16(rsp_hit16),
    .mac_addr16(mac_addr16), .age_limit16(age_limit16), .div_clk16(div_clk16),
    .flush16(flush16), .clear_reused16(clear_reused16),
    .curr_time16(curr_time16), .reused16(reused16), .busy16(busy16)
  );

  always #5 pclk16 = ~pclk16;

  always @(posedge pclk16) begin
    if (p_reset16) n_edges <= 0;
    else           n_edges <= n_edges + 1;
  end

  task automatic step();
    @(posedge pclk16);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // time after n non-reset edges: one tick every div_clk16+1 edges, mod 16
  function automatic logic [3:0] t_at(input int n);
    return 4'((n / (int'(div_clk16) + 1)) % 16);
  endfunction

  function automatic logic [7:0] idx_of(input logic [47:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic is_stale(input logic [3:0] now, input logic [3:0] ts);
    return 4'(now - ts) > age_limit16;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_req(input logic [47:0] sa, input logic [47:0] da, input logic [1:0] sp,
                           input logic [3:0] t_chk, input logic [3:0] t_lrn,
                           output logic [4:0] e_dport, output logic e_hit);
    logic [7:0] i;
    logic [4:0] fl;
    fl    = {1'b0, 4'hF & ~(4'b0001 << sp)};
    e_hit = 1'b0;
    i     = idx_of(da);
    if (da == MAC) e_dport = 5'b10000;
    else if (da == ONES) e_dport = fl;
    else if (m_valid[i] && m_addr[i] == da && !is_stale(t_chk, m_ts[i])) begin
      e_hit   = 1'b1;
      e_dport = (m_port[i] == sp) ? 5'b00000 : 5'(5'b00001 << m_port[i]);
    end else e_dport = fl;
    if (sa != MAC && sa != ONES) begin
      i = idx_of(sa);
      if (m_valid[i] && !is_stale(t_lrn, m_ts[i]) && m_addr[i] != sa) m_reused = 1'b1;
      m_valid[i] = 1'b1; m_addr[i] = sa; m_port[i] = sp; m_ts[i] = t_lrn;
    end
  endtask

  task automatic do_req(input logic [47:0] sa, input logic [47:0] da, input logic [1:0] sp,
                        input int rdy_wait, input int flush_at,
                        output logic [4:0] e_dport, output logic e_hit);
    int w;
    int lat;
    int n_acc;
    w = 0;
    while (req_ready16 !== 1'b1 && w < 20) begin step(); w++; end
    chk("req_ready_wait", 64'(req_ready16), 64'(1));
    req_valid16 = 1'b1; req_saddr16 = sa; req_daddr16 = da; req_sport16 = sp;
    step();
    n_acc = n_edges;
    req_valid16 = 1'b0;
    req_saddr16 = {16'($urandom), $urandom};
    req_daddr16 = {16'($urandom), $urandom};
    req_sport16 = 2'($urandom);
    chk("curr_time", 64'(curr_time16), 64'(t_at(n_acc)));
    chk("busy_req", 64'(busy16), 64'(1));
    model_req(sa, da, sp, t_at(n_acc + 1), t_at(n_acc + 2), e_dport, e_hit);
    lat = 0;
    while (rsp_valid16 !== 1'b1 && lat < 10) begin
      flush16 = (lat == flush_at);
      step();
      flush16 = 1'b0;
      lat++;
    end
    chk("latency", 64'(lat), 64'(4));
    for (int i = 0; i < rdy_wait; i++) begin
      chk("hold_valid", 64'(rsp_valid16), 64'(1));
      chk("hold_dport", 64'(rsp_dport16), 64'(e_dport));
      step();
    end
    chk("rsp_dport", 64'(rsp_dport16), 64'(e_dport));
    chk("rsp_hit", 64'(rsp_hit16), 64'(e_hit));
    rsp_ready16 = 1'b1;
    step();
    rsp_ready16 = 1'b0;
    chk("rsp_drop", 64'(rsp_valid16), 64'(0));
    chk("reused", 64'(reused16), 64'(m_reused));
    if (flush_at >= 0 && flush_at < 4) begin
      chk("ready_pend0", 64'(req_ready16), 64'(0));
      step();
      chk("busy_flush", 64'(busy16), 64'(1));
      chk("ready_pend1", 64'(req_ready16), 64'(0));
      step();
      model_flush();
      chk("ready_after_flush", 64'(req_ready16), 64'(1));
      chk("busy_after_flush", 64'(busy16), 64'(0));
    end else begin
      chk("ready_back", 64'(req_ready16), 64'(1));
    end
  endtask

  logic [4:0]  ed;
  logic        eh;
  logic [47:0] pool [8];
  int          w;

  initial begin
    p_reset16 = 1'b1; req_valid16 = 1'b0; rsp_ready16 = 1'b0;
    req_saddr16 = '0; req_daddr16 = '0; req_sport16 = '0;
    mac_addr16 = MAC; age_limit16 = 4'd15; div_clk16 = 8'd0;
    flush16 = 1'b0; clear_reused16 = 1'b0;
    model_flush(); m_reused = 1'b0;
    pool = '{48'h0A01, 48'h0101, 48'h0000, 48'h0202, MAC, ONES, 48'h1234, 48'hFFFF_0000_0001};

    // reset values
    repeat (3) step();
    chk("rst_ready", 64'(req_ready16), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid16), 64'(0));
    chk("rst_dport", 64'(rsp_dport16), 64'(0));
    chk("rst_hit", 64'(rsp_hit16), 64'(0));
    chk("rst_time", 64'(curr_time16), 64'(0));
    chk("rst_reused", 64'(reused16), 64'(0));
    chk("rst_busy", 64'(busy16), 64'(0));
    p_reset16 = 1'b0;
    step();
    chk("ready_after_rst", 64'(req_ready16), 64'(1));
    chk("time_after_rst", 64'(curr_time16), 64'(t_at(n_edges)));

    // learn, then forward / filter / switch / broadcast
    do_req(48'h0A01, 48'h1234, 2'd1, 1, -1, ed, eh);
    chk("tp_unknown", 64'(rsp_dport16), 64'(5'b01101));
    do_req(MAC, 48'h0A01, 2'd3, 0, -1, ed, eh);
    chk("tp_fwd", 64'(rsp_dport16), 64'(5'b00010));
    chk("tp_fwd_hit", 64'(rsp_hit16), 64'(1));
    do_req(MAC, 48'h0A01, 2'd1, 0, -1, ed, eh);
    chk("tp_filter", 64'(rsp_dport16), 64'(5'b00000));
    do_req(MAC, MAC, 2'd2, 0, -1, ed, eh);
    chk("tp_self", 64'(rsp_dport16), 64'(5'b10000));
    do_req(MAC, ONES, 2'd0, 0, -1, ed, eh);
    chk("tp_bcast", 64'(rsp_dport16), 64'(5'b01110));

    // ageing
    age_limit16 = 4'd3;
    do_req(48'h0C03, MAC, 2'd2, 0, -1, ed, eh);
    repeat (6) step();
    do_req(MAC, 48'h0C03, 2'd0, 0, -1, ed, eh);
    chk("tp_aged", 64'(rsp_dport16), 64'(5'b01110));
    chk("tp_aged_hit", 64'(rsp_hit16), 64'(0));

    // wrap 15 -> 0: learned at time 15, looked up at time 4 (age 5)
    age_limit16 = 4'd5;
    w = 0;
    while (((n_edges + 3) % 16) != 15 && w < 40) begin step(); w++; end
    do_req(48'h0D04, MAC, 2'd1, 0, -1, ed, eh);
    do_req(MAC, 48'h0D04, 2'd0, 0, -1, ed, eh);
    chk("tp_wrap_hit", 64'(rsp_hit16), 64'(1));
    chk("tp_wrap_dport", 64'(rsp_dport16), 64'(5'b00010));
    age_limit16 = 4'd4;
    w = 0;
    while (((n_edges + 3) % 16) != 15 && w < 40) begin step(); w++; end
    do_req(48'h0D04, MAC, 2'd1, 0, -1, ed, eh);
    do_req(MAC, 48'h0D04, 2'd0, 0, -1, ed, eh);
    chk("tp_wrap_stale", 64'(rsp_hit16), 64'(0));

    // overwrite detection, clear, flush
    age_limit16 = 4'd15;
    do_req(48'h0101, MAC, 2'd0, 0, -1, ed, eh);
    do_req(48'h0000, MAC, 2'd2, 0, -1, ed, eh);
    chk("tp_reused_set", 64'(reused16), 64'(1));
    clear_reused16 = 1'b1; step(); clear_reused16 = 1'b0; m_reused = 1'b0;
    chk("tp_reused_clr", 64'(reused16), 64'(0));
    flush16 = 1'b1; step(); flush16 = 1'b0;
    chk("tp_flush_busy", 64'(busy16), 64'(1));
    chk("tp_flush_ready", 64'(req_ready16), 64'(0));
    step();
    model_flush();
    chk("tp_flush_done", 64'(busy16), 64'(0));
    do_req(MAC, 48'h0000, 2'd1, 0, -1, ed, eh);
    chk("tp_flushed_miss", 64'(rsp_hit16), 64'(0));

    // flush during a request is deferred until after the handshake
    do_req(48'h0E05, MAC, 2'd3, 0, -1, ed, eh);
    do_req(MAC, 48'h0E05, 2'd0, 2, 1, ed, eh);
    chk("tp_defer_hit", 64'(rsp_dport16), 64'(5'b01000));
    do_req(MAC, 48'h0E05, 2'd0, 0, -1, ed, eh);
    chk("tp_defer_miss", 64'(rsp_hit16), 64'(0));

    // reset mid-request aborts without learning
    do_req(48'h0F06, MAC, 2'd1, 0, -1, ed, eh);
    chk("tp_pre_rst_ready", 64'(req_ready16), 64'(1));
    req_valid16 = 1'b1; req_saddr16 = 48'h0707; req_daddr16 = 48'h0F06; req_sport16 = 2'd2;
    step();
    req_valid16 = 1'b0;
    repeat (2) step();
    p_reset16 = 1'b1;
    step();
    model_flush(); m_reused = 1'b0;
    chk("tp_abort_valid", 64'(rsp_valid16), 64'(0));
    chk("tp_abort_busy", 64'(busy16), 64'(0));
    chk("tp_abort_time", 64'(curr_time16), 64'(0));
    p_reset16 = 1'b0;
    step();
    chk("tp_abort_ready", 64'(req_ready16), 64'(1));
    do_req(MAC, 48'h0707, 2'd0, 0, -1, ed, eh);
    chk("tp_abort_nolearn", 64'(rsp_dport16), 64'(5'b01110));
    do_req(MAC, 48'h0F06, 2'd0, 0, -1, ed, eh);
    chk("tp_abort_empty", 64'(rsp_hit16), 64'(0));

    // randomized traffic against the reference table
    for (int r = 0; r < 48; r++) begin
      if (r % 12 == 0) age_limit16 = 4'($urandom_range(3, 12));
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 7) == 0) begin
        clear_reused16 = 1'b1; step(); clear_reused16 = 1'b0; m_reused = 1'b0;
        chk("rnd_reused_clr", 64'(reused16), 64'(0));
      end
      do_req(pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1, ed, eh);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
